// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, round constants and controller state type.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;

    typedef logic [1:0] ks_state_t;

    localparam ks_state_t StIdle   = 2'd0;
    localparam ks_state_t StExpand = 2'd1;
    localparam ks_state_t StDone   = 2'd2;

    // Entry 0 is unused so the table is indexed directly by round number.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        rcon_word = (r <= 4'd10) ? {RCON[r], 24'h000000} : 32'h0;
    endfunction

endpackage

// File: rtl/SubBytes.sv
// AES SubBytes: applies the forward S-box to each of the 16 state bytes.
module SubBytes (
    input  logic [127:0] iState,
    output logic [127:0] oState
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        oState = '0;
        for (int i = 0; i < 16; i++) begin
            oState[8*i +: 8] = SBOX[iState[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: expands one key per start into an 11-entry round-key bank.
// Optional KEYSCHED_REUSE_EN: restarting with the already-expanded key skips the expansion.
module aes_key_sched_ctrl #(
    parameter int unsigned NR = aes_pkg::NR_AES128
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStart,
    input  logic [127:0] iKey,
    output logic         oBusy,
    output logic         oDone,
    output logic         oKeyValid,
    input  logic [3:0]   iRkIdx,
    output logic [127:0] oRoundKey
);

    import aes_pkg::*;

    localparam logic [3:0] LastRound = 4'(NR);

    ks_state_t    state_q, state_d;
    logic [3:0]   round_q;
    logic [127:0] bank_q [0:10];
    logic         key_valid_q;
    logic         done_q;
    logic [127:0] round_key_q;

    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [127:0] sbox_out;
    logic [31:0]  w3_rot, t_word, w4, w5, w6, w7;
    logic         reuse;
    logic         unused_sbox;

    assign prev_idx = round_q - 4'd1;
    assign prev_key = (prev_idx <= 4'd10) ? bank_q[prev_idx] : '0;
    assign w3_rot   = {prev_key[23:0], prev_key[31:24]};

    // Only the top word carries data; the zero bytes below fold away.
    SubBytes u_sub_bytes (
        .iState ({w3_rot, 96'b0}),
        .oState (sbox_out)
    );

    assign unused_sbox = ^sbox_out[95:0];

    assign t_word   = sbox_out[127:96] ^ rcon_word(round_q);
    assign w4       = prev_key[127:96] ^ t_word;
    assign w5       = prev_key[95:64] ^ w4;
    assign w6       = prev_key[63:32] ^ w5;
    assign w7       = prev_key[31:0] ^ w6;
    assign next_key = {w4, w5, w6, w7};

`ifdef KEYSCHED_REUSE_EN
    assign reuse = key_valid_q && (iKey == bank_q[0]);
`else
    assign reuse = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (iStart) state_d = reuse ? StDone : StExpand;
            StExpand: if (round_q == LastRound) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= StIdle;
            round_q     <= 4'd0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            round_key_q <= '0;
            for (int i = 0; i <= 10; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            done_q      <= (state_q == StDone);
            round_key_q <= (iRkIdx <= 4'd10) ? bank_q[iRkIdx] : '0;
            unique case (state_q)
                StIdle: begin
                    if (iStart) begin
                        round_q <= 4'd1;
                        if (!reuse) begin
                            bank_q[0]   <= iKey;
                            key_valid_q <= 1'b0;
                        end
                    end
                end
                StExpand: begin
                    bank_q[round_q] <= next_key;
                    round_q         <= round_q + 4'd1;
                end
                StDone:  key_valid_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign oBusy     = (state_q == StExpand);
    assign oDone     = done_q;
    assign oKeyValid = key_valid_q;
    assign oRoundKey = round_key_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: directed sequence with random keys against a FIPS-197 word model.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy, done, key_valid;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [0:255][7:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] exp_rk [0:10];

    aes_key_sched_ctrl #(.NR(10)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iStart    (start),
        .iKey      (key),
        .oBusy     (busy),
        .oDone     (done),
        .oKeyValid (key_valid),
        .iRkIdx    (rk_idx),
        .oRoundKey (round_key)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Word-level key expansion with round constants generated by GF(2^8) doubling.
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents start for one edge and returns the number of edges until oDone is seen.
    task automatic run_start(input logic [127:0] k, output int lat, output int busy_cnt);
        key = k;
        start = 1'b1;
        step();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = 99;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            step();
            chk($sformatf("%s_rk%0d", tag, i), round_key, (i <= 10) ? exp_rk[i] : 128'h0);
        end
    endtask

    initial begin
        int lat, bcnt, dones;
        logic [127:0] k1;

        rst = 1'b1; start = 1'b0; key = '0; rk_idx = 4'd0;
        step(); step();
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        chk("rst_valid", 128'(key_valid), 128'h0);
        chk("rst_rk", round_key, 128'h0);
        rst = 1'b0;
        step();

        // Known-answer key
        model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_start(128'h2b7e151628aed2a6abf7158809cf4f3c, lat, bcnt);
        chk("kat_latency", 128'(lat), 128'd11);
        chk("kat_busy_cycles", 128'(bcnt), 128'd10);
        chk("kat_valid", 128'(key_valid), 128'h1);
        step();
        chk("kat_done_pulse", 128'(done), 128'h0);
        sweep("kat");
        rk_idx = 4'd1; step();
        chk("kat_gold_rk1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rk_idx = 4'd10; step();
        chk("kat_gold_rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Restart with the same key
        run_start(128'h2b7e151628aed2a6abf7158809cf4f3c, lat, bcnt);
`ifdef KEYSCHED_REUSE_EN
        chk("same_key_latency", 128'(lat), 128'd1);
`else
        chk("same_key_latency", 128'(lat), 128'd11);
`endif
        chk("same_key_valid", 128'(key_valid), 128'h1);
        rk_idx = 4'd5; step();
        chk("same_key_rk5", round_key, exp_rk[5]);

        // All-zero key
        model_expand(128'h0);
        run_start(128'h0, lat, bcnt);
        chk("zero_latency", 128'(lat), 128'd11);
        rk_idx = 4'd1; step();
        chk("zero_gold_rk1", round_key, 128'h62636363626363636263636362636363);
        rk_idx = 4'd10; step();
        chk("zero_gold_rk10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Random keys, full sweep each
        for (int j = 0; j < 3; j++) begin
            k1 = rand_key();
            model_expand(k1);
            run_start(k1, lat, bcnt);
            chk($sformatf("rand%0d_latency", j), 128'(lat), 128'd11);
            sweep($sformatf("rand%0d", j));
        end

        // Start spammed during expansion with different keys
        k1 = rand_key();
        model_expand(k1);
        key = k1; start = 1'b1;
        step();
        dones = 0;
        lat = 99;
        for (int n = 1; n <= 30; n++) begin
            start = 1'b1;
            key = rand_key();
            step();
            if (done) begin
                dones++;
                lat = n;
                break;
            end
        end
        start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            step();
            if (done) dones++;
        end
        chk("spam_latency", 128'(lat), 128'd11);
        chk("spam_done_count", 128'(dones), 128'd1);
        sweep("spam");

        // Reset at the fifth expansion cycle
        k1 = rand_key();
        key = k1; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 4; n++) step();
        chk("mid_busy_before", 128'(busy), 128'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 128'(busy), 128'h0);
        chk("mid_rst_done", 128'(done), 128'h0);
        chk("mid_rst_valid", 128'(key_valid), 128'h0);
        chk("mid_rst_rk", round_key, 128'h0);
        for (int r = 0; r <= 10; r++) exp_rk[r] = '0;
        sweep("mid_zero");
        model_expand(k1);
        run_start(k1, lat, bcnt);
        chk("post_rst_latency", 128'(lat), 128'd11);
        sweep("post_rst");

        // Start coincident with reset is dropped
        rst = 1'b1; start = 1'b1; key = rand_key();
        step();
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst_start_busy", 128'(busy), 128'h0);
        chk("rst_start_valid", 128'(key_valid), 128'h0);

        // A different key after a completed one always expands fully
        k1 = rand_key();
        model_expand(k1);
        run_start(k1, lat, bcnt);
        k1 = rand_key();
        model_expand(k1);
        run_start(k1, lat, bcnt);
        chk("new_key_latency", 128'(lat), 128'd11);
        sweep("new_key");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
